imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, registered immediate generator for the ID stage of the pipeline. Decodes the 5-bit opcode in `InsIn[4:0]`, builds the sign- or zero-extended immediate at `XLEN` bits, and carries an instruction tag (PC) alongside. It replaces the combinational immediate path with a valid/ready stage and a 2-entry skid buffer, so IF stalls and branch flushes no longer corrupt the immediate seen by the ALU mux and the PC+offset adder.

## Interface
- `XLEN`, 32: immediate and datapath width; legal values 32, 64.
- `TAG_W`, 32: width of the tag carried with each instruction (normally the PC).
- `SHAMT_W`, 6: shift-amount field width, taken from `InsIn[20+SHAMT_W-1:20]`; legal range 5..6.
- `Clk`, input, 1: the only clock; all state updates on its rising edge.
- `Rst_n`, input, 1: synchronous, active-low reset.
- `FlushIn`, input, 1: discards all held entries.
- `InsIn`, input, 32: instruction from IMem / IF-ID.
- `TagIn`, input, `TAG_W`: tag accompanying `InsIn`.
- `InsValidIn`, input, 1: `InsIn` and `TagIn` are valid.
- `InsReadyOut`, output, 1: the stage accepts an instruction this cycle.
- `Imm32Out`, output, `XLEN`: immediate to PCPlusOffsetAdder, ALUMUX and DataMUX.
- `TagOut`, output, `TAG_W`: tag of the entry presented.
- `ImmKindOut`, output, 3: immediate class of the entry presented.
- `ImmValidOut`, output, 1: output entry is valid.
- `ImmReadyIn`, input, 1: downstream consumes the output entry.

## Operation
- Immediate classes (`ImmKindOut` encoding, opcode → class):
  - NONE=0: any other opcode; immediate 0.
  - ISX=1: opcodes 00010, 01111, 10100; sign-extend `InsIn[31:20]`.
  - IZX=2: opcodes 00101, 00111, 01001; zero-extend `InsIn[31:20]`.
  - SHAMT=3: opcodes 01011, 01101; zero-extend `SHAMT_W` bits from bit 20.
  - UP=4: opcode 01110; `{InsIn[31:12],12'h000}`, sign-extended from bit 31 when `XLEN`=64.
  - SSX=5: opcodes 10000, 10001, 10010; sign-extend `{InsIn[31:25],InsIn[11:7]}`.
  - J20=6: opcode 10011; sign-extend `InsIn[31:12]`.
- All extension is to the full `XLEN`. Opcodes outside this list are not errors; they yield NONE and zero.
- Decoding happens on the input side. The stored entry is {imm, tag, kind}.
- Storage: main register M, which drives the outputs, and skid register S.
- Accept: `InsValidIn & InsReadyOut`.
- Pop: `ImmValidOut & ImmReadyIn`.
- Entry flow:
  - Accept while M is empty, or M is popping with S empty: the entry is written into M.
  - Accept while M is full and not popping: the entry is written into S.
  - Pop while S is full: S moves to M and S empties.
- `InsReadyOut` = !S.valid, taken from a register and not combinational from `ImmReadyIn`.

## Timing
- Latency is 1 cycle. An instruction accepted at edge n is on the outputs after edge n with `ImmValidOut`=1.
- Throughput is 1 instruction per cycle while `ImmReadyIn`=1.
- Outputs are held stable while `ImmValidOut`=1 and `ImmReadyIn`=0.
- Reset is synchronous. While `Rst_n`=0 at an edge, both entries are cleared and the inputs are ignored.
- Reset values:
  - `ImmValidOut`=0.
  - `Imm32Out`=0.
  - `TagOut`=0.
  - `ImmKindOut`=NONE.
  - `InsReadyOut`=1.
- Reset mid-stream drops all held entries; no partial entry survives.
- `FlushIn`=1 at an edge clears M.valid and S.valid and blocks that cycle's accept. The data fields may hold stale values.
- Priority: reset > flush > pop/accept.
- Both entries full: `InsReadyOut`=0, and `InsValidIn` is ignored.
- Pop and accept in the same cycle with S empty: M is replaced in place, with no bubble.
- Pop and accept in the same cycle with S full cannot occur, because `InsReadyOut`=0.

## Structure
- Shared package `imm_gen_pkg`:
  - Opcode localparams.
  - The 3-bit ImmKind encoding.
  - `XLEN`/`SHAMT_W` legality rules.
- Sub-module `imm_decode`: purely combinational opcode → {kind, `XLEN`-bit imm}, parametrised on `XLEN` and `SHAMT_W`. It is instantiated once, on the input side.
- The skid-buffer control lives in `imm_gen_pipe`.

## Test plan
- `XLEN`=32, `InsIn`=0xFFF00002 accepted, `ImmReadyIn`=1 → next cycle `Imm32Out`=0xFFFFFFFF, `ImmKindOut`=1, `TagOut` equals the tag sent.
- `InsIn`=0x1234500E → `Imm32Out`=0x12345000, kind 4. `InsIn`=0x80000013 → 0xFFF80000, kind 6. `InsIn`=0x03F0000B → 0x0000003F, kind 3.
- `XLEN`=64, `InsIn`=0x8000000E → `Imm32Out`=0xFFFFFFFF80000000. `InsIn`=0xFE000F90 → 0xFFFFFFFFFFFFFFFF, kind 5.
- Hold `ImmReadyIn`=0 and stream 3 instructions with tags 1, 2, 3 → `InsReadyOut` falls after 2 accepts, tag 3 waits. Release `ImmReadyIn` → tags 1, 2, 3 come out in order, 1 per cycle, with no loss or duplicate.
- With M and S full, pulse `FlushIn` in the same cycle as `InsValidIn` → next cycle `ImmValidOut`=0, `InsReadyOut`=1, and the flushed-cycle instruction is never output.
- Pull `Rst_n` low for 1 cycle mid-stream → every output is at its reset value the following cycle, and an instruction accepted afterwards appears 1 cycle later.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the ID-stage immediate generator: opcode values,
// immediate-class encoding and parameter legality rules.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    KIND_NONE  = 3'd0,
    KIND_ISX   = 3'd1,
    KIND_IZX   = 3'd2,
    KIND_SHAMT = 3'd3,
    KIND_UP    = 3'd4,
    KIND_SSX   = 3'd5,
    KIND_J20   = 3'd6
  } imm_kind_e;

  localparam logic [4:0] OP_ISX_0   = 5'b00010;
  localparam logic [4:0] OP_ISX_1   = 5'b01111;
  localparam logic [4:0] OP_ISX_2   = 5'b10100;
  localparam logic [4:0] OP_IZX_0   = 5'b00101;
  localparam logic [4:0] OP_IZX_1   = 5'b00111;
  localparam logic [4:0] OP_IZX_2   = 5'b01001;
  localparam logic [4:0] OP_SHAMT_0 = 5'b01011;
  localparam logic [4:0] OP_SHAMT_1 = 5'b01101;
  localparam logic [4:0] OP_UP      = 5'b01110;
  localparam logic [4:0] OP_SSX_0   = 5'b10000;
  localparam logic [4:0] OP_SSX_1   = 5'b10001;
  localparam logic [4:0] OP_SSX_2   = 5'b10010;
  localparam logic [4:0] OP_J20     = 5'b10011;

  function automatic bit xlen_legal(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit shamt_legal(int shamt_w);
    return (shamt_w >= 5) && (shamt_w <= 6);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle of the immediate stage.
interface imm_gen_pipe_if
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             FlushIn;
  logic [31:0]      InsIn;
  logic [TAG_W-1:0] TagIn;
  logic             InsValidIn;
  logic             InsReadyOut;
  logic [XLEN-1:0]  Imm32Out;
  logic [TAG_W-1:0] TagOut;
  imm_kind_e        ImmKindOut;
  logic             ImmValidOut;
  logic             ImmReadyIn;

  // master: fetch/consumer side driving the stage; slave: the stage itself
  modport master (
    output FlushIn, InsIn, TagIn, InsValidIn, ImmReadyIn,
    input  InsReadyOut, Imm32Out, TagOut, ImmKindOut, ImmValidOut
  );

  modport slave (
    input  FlushIn, InsIn, TagIn, InsValidIn, ImmReadyIn,
    output InsReadyOut, Imm32Out, TagOut, ImmKindOut, ImmValidOut
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode -> {immediate class, XLEN-bit immediate} decoder.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 6
) (
  input  logic [31:0]     ins,
  output imm_kind_e       kind,
  output logic [XLEN-1:0] imm
);

  if (!xlen_legal(XLEN) || !shamt_legal(SHAMT_W)) begin : g_cfg_check
    $error("imm_decode: XLEN must be 32 or 64 and SHAMT_W must be 5..6");
  end

  // Bits 6:5 carry no immediate information in any class.
  logic unused_ins_bits;
  assign unused_ins_bits = ^ins[6:5];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    kind = KIND_NONE;
    imm  = '0;
    case (ins[4:0])
      OP_ISX_0, OP_ISX_1, OP_ISX_2: begin
        kind = KIND_ISX;
        imm  = XLEN'($signed(ins[31:20]));
      end
      OP_IZX_0, OP_IZX_1, OP_IZX_2: begin
        kind = KIND_IZX;
        imm  = XLEN'(ins[31:20]);
      end
      OP_SHAMT_0, OP_SHAMT_1: begin
        kind = KIND_SHAMT;
        imm  = XLEN'(ins[20 +: SHAMT_W]);
      end
      OP_UP: begin
        kind = KIND_UP;
        imm  = XLEN'($signed({ins[31:12], 12'h000}));
      end
      OP_SSX_0, OP_SSX_1, OP_SSX_2: begin
        kind = KIND_SSX;
        imm  = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      OP_J20: begin
        kind = KIND_J20;
        imm  = XLEN'($signed(ins[31:12]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate stage: decode on input, main register M drives the
// outputs, skid register S absorbs one entry so ready never depends on ImmReadyIn.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter int SHAMT_W = 6
) (
  input logic           Clk,
  input logic           Rst_n,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    imm_kind_e        kind;
  } entry_t;

  entry_t          m_q, s_q, in_entry;
  logic            m_valid, s_valid;
  imm_kind_e       dec_kind;
  logic [XLEN-1:0] dec_imm;
  logic            accept, pop;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .ins  (bus.InsIn),
    .kind (dec_kind),
    .imm  (dec_imm)
  );

  assign in_entry = '{imm: dec_imm, tag: bus.TagIn, kind: dec_kind};
  assign accept   = bus.InsValidIn & ~s_valid;
  assign pop      = m_valid & bus.ImmReadyIn;

  // Priority: reset > flush > pop/accept. Pop+accept with S full cannot
  // happen because ready is low whenever S holds an entry.
  // NOTE: state uses non-blocking assignments; the data registers are reset
  // too, so the outputs read zero after reset rather than stale values.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else if (bus.FlushIn) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (pop) begin
      if (s_valid) begin
        m_q     <= s_q;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_q <= in_entry;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!m_valid) begin
        m_q     <= in_entry;
        m_valid <= 1'b1;
      end else begin
        s_q     <= in_entry;
        s_valid <= 1'b1;
      end
    end
  end

  assign bus.InsReadyOut = ~s_valid;
  assign bus.ImmValidOut = m_valid;
  assign bus.Imm32Out    = m_q.imm;
  assign bus.TagOut      = m_q.tag;
  assign bus.ImmKindOut  = m_q.kind;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 stages driven in lockstep, checked
// each cycle against a FIFO-of-instructions model plus hand-computed literals.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus64.FlushIn    = bus32.FlushIn;
  assign bus64.InsIn      = bus32.InsIn;
  assign bus64.TagIn      = bus32.TagIn;
  assign bus64.InsValidIn = bus32.InsValidIn;
  assign bus64.ImmReadyIn = bus32.ImmReadyIn;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_W(6)) u_dut32 (
    .Clk (clk), .Rst_n (rst_n), .bus (bus32)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SHAMT_W(6)) u_dut64 (
    .Clk (clk), .Rst_n (rst_n), .bus (bus64)
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] tag;
  } ins_t;

  ins_t mq[$];          // entries held by the stage, head = presented entry
  bit   zero_data;      // outputs must read zero: reset seen, nothing accepted since
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate rules as plain signed arithmetic; result is the 64-bit value,
  // whose low 32 bits are the XLEN=32 answer.
  function automatic void ref_decode(input logic [31:0] ins, output logic [63:0] imm,
                                     output int kind);
    longint x;
    x    = 0;
    kind = 0;
    case (int'(ins[4:0]))
      2, 15, 20: begin kind = 1; x = longint'(ins[31:20]); if (ins[31]) x -= 4096; end
      5, 7, 9:   begin kind = 2; x = longint'(ins[31:20]); end
      11, 13:    begin kind = 3; x = longint'(ins[25:20]); end
      14: begin
        kind = 4;
        x = longint'(ins[31:12]) * 4096;
        if (ins[31]) x -= (longint'(1) << 32);
      end
      16, 17, 18: begin
        kind = 5;
        x = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) x -= 4096;
      end
      19: begin kind = 6; x = longint'(ins[31:12]); if (ins[31]) x -= (longint'(1) << 20); end
      default: ;
    endcase
    imm = 64'(x);
  endfunction

  task automatic compare_cycle();
    logic [63:0] e_imm;
    int          e_kind;
    check("ready32", 64'(bus32.InsReadyOut), 64'(mq.size() < 2));
    check("ready64", 64'(bus64.InsReadyOut), 64'(mq.size() < 2));
    check("valid32", 64'(bus32.ImmValidOut), 64'(mq.size() > 0));
    check("valid64", 64'(bus64.ImmValidOut), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      ref_decode(mq[0].ins, e_imm, e_kind);
      check("imm32",  64'(bus32.Imm32Out),   {32'h0, e_imm[31:0]});
      check("imm64",  bus64.Imm32Out,        e_imm);
      check("kind32", 64'(bus32.ImmKindOut), 64'(e_kind));
      check("kind64", 64'(bus64.ImmKindOut), 64'(e_kind));
      check("tag32",  64'(bus32.TagOut),     64'(mq[0].tag));
      check("tag64",  64'(bus64.TagOut),     64'(mq[0].tag));
    end else if (zero_data) begin
      check("rst_imm32", 64'(bus32.Imm32Out),   64'h0);
      check("rst_imm64", bus64.Imm32Out,        64'h0);
      check("rst_kind",  64'(bus32.ImmKindOut), 64'h0);
      check("rst_tag",   64'(bus32.TagOut),     64'h0);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                      input logic rdy, input logic fl, input logic rst_in);
    bit do_pop, do_acc;
    bus32.InsValidIn = v;
    bus32.InsIn      = ins;
    bus32.TagIn      = tag;
    bus32.ImmReadyIn = rdy;
    bus32.FlushIn    = fl;
    rst_n            = rst_in;
    @(posedge clk);
    if (!rst_in) begin
      mq.delete();
      zero_data = 1'b1;
    end else if (fl) begin
      mq.delete();
    end else begin
      do_pop = (mq.size() > 0) && rdy;
      do_acc = v && (mq.size() < 2);
      if (do_pop) void'(mq.pop_front());
      if (do_acc) begin
        mq.push_back('{ins: ins, tag: tag});
        zero_data = 1'b0;
      end
    end
    #1;
    compare_cycle();
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] tag);
    step(1'b1, ins, tag, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] m_imm;
    int          m_kind;
    zero_data = 1'b1;

    // Model pinned against hand-computed values
    ref_decode(32'hFFF00002, m_imm, m_kind);
    check("model_isx", m_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_decode(32'hFE000F90, m_imm, m_kind);
    check("model_ssx", m_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    ref_decode(32'h8000000E, m_imm, m_kind);
    check("model_up",  m_imm, 64'hFFFF_FFFF_8000_0000);

    // Reset
    step(1'b1, 32'hFFF00002, 32'h77, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hFFF00002, 32'h77, 1'b1, 1'b0, 1'b0);
    check("lit_rst_ready", 64'(bus32.InsReadyOut), 64'h1);
    check("lit_rst_valid", 64'(bus32.ImmValidOut), 64'h0);

    // Decode vectors, back to back at full throughput
    send(32'hFFF00002, 32'hA0);
    check("lit_isx_imm",  64'(bus32.Imm32Out),   64'hFFFF_FFFF);
    check("lit_isx_kind", 64'(bus32.ImmKindOut), 64'd1);
    check("lit_isx_tag",  64'(bus32.TagOut),     64'hA0);
    send(32'h1234500E, 32'hA1);
    check("lit_up_imm",   64'(bus32.Imm32Out),   64'h1234_5000);
    check("lit_up_kind",  64'(bus32.ImmKindOut), 64'd4);
    send(32'h80000013, 32'hA2);
    check("lit_j20_imm",  64'(bus32.Imm32Out),   64'hFFF8_0000);
    check("lit_j20_kind", 64'(bus32.ImmKindOut), 64'd6);
    send(32'h03F0000B, 32'hA3);
    check("lit_sh_imm",   64'(bus32.Imm32Out),   64'h3F);
    check("lit_sh_kind",  64'(bus32.ImmKindOut), 64'd3);
    send(32'h8000000E, 32'hA4);
    check("lit_up64_imm", bus64.Imm32Out,        64'hFFFF_FFFF_8000_0000);
    send(32'hFE000F90, 32'hA5);
    check("lit_ssx64_imm",  bus64.Imm32Out,        64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_ssx64_kind", 64'(bus64.ImmKindOut), 64'd5);
    send(32'hFFF00005, 32'hA6);
    check("lit_izx64_imm", bus64.Imm32Out,        64'h0000_0000_0000_0FFF);
    send(32'hFFFFFFFF, 32'hA7);
    check("lit_none_imm",  bus64.Imm32Out,        64'h0);
    check("lit_none_kind", 64'(bus64.ImmKindOut), 64'd0);
    idle(1'b1);

    // Backpressure: tags 1, 2 fill M and S; tag 3 waits
    step(1'b1, 32'h00100002, 32'd1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00200002, 32'd2, 1'b0, 1'b0, 1'b1);
    check("lit_bp_ready", 64'(bus32.InsReadyOut), 64'h0);
    step(1'b1, 32'h00300002, 32'd3, 1'b0, 1'b0, 1'b1);
    check("lit_bp_hold_tag", 64'(bus32.TagOut), 64'd1);
    check("lit_bp_hold_imm", 64'(bus32.Imm32Out), 64'h1);
    step(1'b1, 32'h00300002, 32'd3, 1'b1, 1'b0, 1'b1);
    check("lit_rel_tag2", 64'(bus32.TagOut), 64'd2);
    step(1'b1, 32'h00300002, 32'd3, 1'b1, 1'b0, 1'b1);
    check("lit_rel_tag3", 64'(bus32.TagOut), 64'd3);
    idle(1'b1);
    check("lit_rel_empty", 64'(bus32.ImmValidOut), 64'h0);

    // Flush with both entries full and a valid instruction offered
    step(1'b1, 32'h00A00005, 32'd10, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00B00005, 32'd11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00C00005, 32'd12, 1'b0, 1'b1, 1'b1);
    check("lit_fl_valid", 64'(bus32.ImmValidOut), 64'h0);
    check("lit_fl_ready", 64'(bus32.InsReadyOut), 64'h1);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-stream, then one instruction straight after
    step(1'b1, 32'h00D00005, 32'd20, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00E00005, 32'd21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00F00005, 32'd22, 1'b1, 1'b0, 1'b0);
    check("lit_mrst_imm", 64'(bus32.Imm32Out), 64'h0);
    check("lit_mrst_tag", 64'(bus32.TagOut),   64'h0);
    send(32'hFFF00005, 32'h55);
    check("lit_post_rst_tag", 64'(bus32.TagOut),   64'h55);
    check("lit_post_rst_imm", 64'(bus32.Imm32Out), 64'hFFF);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 32'(i),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
